// File: rtl/lc4_writeback_stage_pkg.sv
// Opcode encodings, NZP branch masks and opcode classification for the
// LC4 execute/writeback stage (shared with the ALU).
package lc4_writeback_stage_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_BRZ   = 5'b00001;
  localparam logic [4:0] OP_BRZP  = 5'b00010;
  localparam logic [4:0] OP_BRNP  = 5'b00011;
  localparam logic [4:0] OP_BRNZ  = 5'b00100;
  localparam logic [4:0] OP_ADD   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_ADDI  = 5'b00111;
  localparam logic [4:0] OP_JSR   = 5'b01000;
  localparam logic [4:0] OP_AND   = 5'b01001;
  localparam logic [4:0] OP_RTI   = 5'b01010;
  localparam logic [4:0] OP_CONST = 5'b01011;
  localparam logic [4:0] OP_SLL   = 5'b01100;
  localparam logic [4:0] OP_SRL   = 5'b01101;
  localparam logic [4:0] OP_SDRH  = 5'b01110;
  localparam logic [4:0] OP_SDRL  = 5'b01111;
  localparam logic [4:0] OP_CHK   = 5'b10000;
  localparam logic [4:0] OP_SDL   = 5'b10010;
  localparam logic [4:0] OP_XMP   = 5'b10011;
  localparam logic [4:0] OP_TCS   = 5'b10100;
  localparam logic [4:0] OP_TCDH  = 5'b10101;

  localparam logic [2:0] MASK_BRZ  = 3'b010;
  localparam logic [2:0] MASK_BRZP = 3'b011;
  localparam logic [2:0] MASK_BRNP = 3'b101;
  localparam logic [2:0] MASK_BRNZ = 3'b110;
  localparam logic [2:0] NZP_RESET = 3'b010;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_WRITE,
    CLS_JSR,
    CLS_BRANCH,
    CLS_RTI,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_NOP:                                   return CLS_NOP;
      OP_BRZ, OP_BRZP, OP_BRNP, OP_BRNZ:        return CLS_BRANCH;
      OP_JSR:                                   return CLS_JSR;
      OP_RTI:                                   return CLS_RTI;
      OP_ADD, OP_SUB, OP_ADDI, OP_AND, OP_CONST,
      OP_SLL, OP_SRL, OP_SDRH, OP_SDRL, OP_CHK,
      OP_SDL, OP_XMP, OP_TCS, OP_TCDH:          return CLS_WRITE;
      default:                                  return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/lc4_branch_cond.sv
// Branch resolution: selects the NZP mask for a conditional branch opcode
// and reports taken when any selected condition code is set.
module lc4_branch_cond
  import lc4_writeback_stage_pkg::*;
(
  input  logic [4:0] opcode_i,
  input  logic [2:0] nzp_i,
  output logic       taken_o
);

  logic [2:0] mask;

  always_comb begin
    case (opcode_i)
      OP_BRZ:  mask = MASK_BRZ;
      OP_BRZP: mask = MASK_BRZP;
      OP_BRNP: mask = MASK_BRNP;
      OP_BRNZ: mask = MASK_BRNZ;
      default: mask = 3'b000;
    endcase
  end

  assign taken_o = |(nzp_i & mask);

endmodule

// File: rtl/lc4_writeback_stage.sv
// LC4 execute/writeback stage register: register-file write, NZP/carry flags,
// branch/JSR/RTI redirect with wrong-path squash, retired-instruction counter.
module lc4_writeback_stage
  import lc4_writeback_stage_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  parameter int DADDR     = 4,
  parameter int INSN      = 19,
  parameter int IADDR     = 10,
  parameter int PERF_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic [INSN:0]        i_insn,
  input  logic [IADDR:0]       i_pc,
  input  logic [WORD_SIZE-1:0] i_alu_result,
  output logic                 o_carry,
  output logic [2:0]           o_nzp,
  output logic                 o_wb_valid,
  output logic                 o_rf_we,
  output logic [DADDR:0]       o_rf_rd,
  output logic [WORD_SIZE-1:0] o_rf_wdata,
  output logic                 o_redirect,
  output logic [IADDR:0]       o_target,
  output logic                 o_illegal,
  output logic [PERF_W-1:0]    o_retired
);

  logic [4:0]           opcode;
  logic [DADDR:0]       rd;
  op_class_e            op_class;
  logic                 br_taken;
  logic                 accept;
  logic [IADDR:0]       pc_inc;
  logic [WORD_SIZE-1:0] jsr_wdata;
  logic [2:0]           res_nzp;
  logic [2:0]           jsr_nzp;
  logic                 unused_insn_bits;

  logic                 carry_q,    carry_d;
  logic [2:0]           nzp_q,      nzp_d;
  logic                 wb_valid_q, wb_valid_d;
  logic                 rf_we_q,    rf_we_d;
  logic [DADDR:0]       rf_rd_q,    rf_rd_d;
  logic [WORD_SIZE-1:0] rf_wdata_q, rf_wdata_d;
  logic                 redirect_q, redirect_d;
  logic [IADDR:0]       target_q,   target_d;
  logic                 illegal_q,  illegal_d;
  logic [PERF_W-1:0]    retired_q,  retired_d;

  assign opcode           = i_insn[INSN -: 5];
  assign rd               = i_insn[INSN-5 -: DADDR+1];
  assign unused_insn_bits = ^i_insn[INSN-DADDR-6:0];
  assign op_class         = classify(opcode);

  lc4_branch_cond u_branch_cond (
    .opcode_i (opcode),
    .nzp_i    (nzp_q),
    .taken_o  (br_taken)
  );

  // A slot presented while a redirect is outstanding is on the wrong path.
  assign accept    = i_valid & ~i_stall & ~redirect_q;
  assign pc_inc    = i_pc + {{IADDR{1'b0}}, 1'b1};
  assign jsr_wdata = {{(WORD_SIZE-IADDR-1){1'b0}}, pc_inc};
  assign res_nzp   = {i_alu_result[WORD_SIZE-1], i_alu_result == '0,
                      ~i_alu_result[WORD_SIZE-1] & (i_alu_result != '0)};
  assign jsr_nzp   = {1'b0, pc_inc == '0, pc_inc != '0};

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch to remember the old value.
    wb_valid_d = 1'b0;
    rf_we_d    = 1'b0;
    redirect_d = 1'b0;
    illegal_d  = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    target_d   = target_q;
    nzp_d      = nzp_q;
    carry_d    = carry_q;
    retired_d  = retired_q;

    if (accept) begin
      wb_valid_d = 1'b1;
      retired_d  = retired_q + {{(PERF_W-1){1'b0}}, 1'b1};
      case (op_class)
        CLS_WRITE: begin
          rf_we_d    = 1'b1;
          rf_rd_d    = rd;
          rf_wdata_d = i_alu_result;
          nzp_d      = res_nzp;
          if (opcode == OP_CHK)       carry_d = i_alu_result[0];
          else if (opcode == OP_TCDH) carry_d = 1'b0;
        end
        CLS_JSR: begin
          rf_we_d    = 1'b1;
          rf_rd_d    = rd;
          rf_wdata_d = jsr_wdata;
          nzp_d      = jsr_nzp;
          redirect_d = 1'b1;
          target_d   = i_alu_result[IADDR:0];
        end
        CLS_BRANCH: begin
          if (br_taken) begin
            redirect_d = 1'b1;
            target_d   = i_alu_result[IADDR:0];
          end
        end
        CLS_RTI: begin
          redirect_d = 1'b1;
          target_d   = i_alu_result[IADDR:0];
        end
        CLS_ILLEGAL: illegal_d = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q    <= 1'b0;
      nzp_q      <= NZP_RESET;
      wb_valid_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else if (!i_stall) begin
      carry_q    <= carry_d;
      nzp_q      <= nzp_d;
      wb_valid_q <= wb_valid_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
    end
  end

  assign o_carry    = carry_q;
  assign o_nzp      = nzp_q;
  assign o_wb_valid = wb_valid_q;
  assign o_rf_we    = rf_we_q;
  assign o_rf_rd    = rf_rd_q;
  assign o_rf_wdata = rf_wdata_q;
  assign o_redirect = redirect_q;
  assign o_target   = target_q;
  assign o_illegal  = illegal_q;
  assign o_retired  = retired_q;

endmodule

// File: tb/tb_lc4_writeback_stage.sv
// Directed bench for lc4_writeback_stage: writes, flags, branches, squash,
// JSR wrap, carry, stall freeze, illegal opcode and reset during redirect.
module tb_lc4_writeback_stage;
  import lc4_writeback_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_stall;
  logic [19:0] i_insn;
  logic [10:0] i_pc;
  logic [63:0] i_alu_result;
  logic        o_carry;
  logic [2:0]  o_nzp;
  logic        o_wb_valid;
  logic        o_rf_we;
  logic [4:0]  o_rf_rd;
  logic [63:0] o_rf_wdata;
  logic        o_redirect;
  logic [10:0] o_target;
  logic        o_illegal;
  logic [31:0] o_retired;

  int compared   = 0;
  int mismatched = 0;

  lc4_writeback_stage dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_stall      (i_stall),
    .i_insn       (i_insn),
    .i_pc         (i_pc),
    .i_alu_result (i_alu_result),
    .o_carry      (o_carry),
    .o_nzp        (o_nzp),
    .o_wb_valid   (o_wb_valid),
    .o_rf_we      (o_rf_we),
    .o_rf_rd      (o_rf_rd),
    .o_rf_wdata   (o_rf_wdata),
    .o_redirect   (o_redirect),
    .o_target     (o_target),
    .o_illegal    (o_illegal),
    .o_retired    (o_retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [4:0] op,
                       input logic [4:0] rd, input logic [10:0] pc, input logic [63:0] res);
    i_valid      = v;
    i_stall      = s;
    i_insn       = {op, rd, 10'h000};
    i_pc         = pc;
    i_alu_result = res;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, OP_NOP, 5'd0, 11'h000, 64'h0);
    step();
    step();
    check("rst_wb_valid", o_wb_valid, 0);
    check("rst_rf_we",    o_rf_we,    0);
    check("rst_wdata",    o_rf_wdata, 0);
    check("rst_redirect", o_redirect, 0);
    check("rst_nzp",      o_nzp,      3'b010);
    check("rst_carry",    o_carry,    0);
    check("rst_retired",  o_retired,  0);

    rst = 1'b0;
    drive(1'b1, 1'b0, OP_ADDI, 5'd3, 11'h010, 64'h5);
    step();
    check("addi_rf_we",   o_rf_we,    1);
    check("addi_wdata",   o_rf_wdata, 64'h5);
    check("addi_rd",      o_rf_rd,    5'd3);
    check("addi_nzp",     o_nzp,      3'b001);
    check("addi_retired", o_retired,  1);

    drive(1'b1, 1'b0, OP_SUB, 5'd4, 11'h011, 64'h0);
    step();
    check("sub_nzp",      o_nzp,      3'b010);
    check("sub_retired",  o_retired,  2);

    // Branch sees the NZP just written by SUB.
    drive(1'b1, 1'b0, OP_BRZ, 5'd0, 11'h012, 64'h040);
    step();
    check("brz_redirect", o_redirect, 1);
    check("brz_target",   o_target,   11'h040);
    check("brz_rf_we",    o_rf_we,    0);
    check("brz_retired",  o_retired,  3);

    drive(1'b1, 1'b0, OP_ADD, 5'd5, 11'h013, 64'h7);
    step();
    check("sq1_wb_valid", o_wb_valid, 0);
    check("sq1_rf_we",    o_rf_we,    0);
    check("sq1_redirect", o_redirect, 0);
    check("sq1_nzp",      o_nzp,      3'b010);
    check("sq1_retired",  o_retired,  3);

    drive(1'b1, 1'b0, OP_ADD, 5'd6, 11'h040, 64'h8000_0000_0000_0000);
    step();
    check("addneg_nzp",   o_nzp,      3'b100);
    check("addneg_ret",   o_retired,  4);

    drive(1'b1, 1'b0, OP_BRNP, 5'd0, 11'h041, 64'h123);
    step();
    check("brnp_redirect", o_redirect, 1);
    check("brnp_target",   o_target,   11'h123);

    drive(1'b1, 1'b0, OP_ADD, 5'd1, 11'h042, 64'h9);
    step();
    check("sq2_wb_valid", o_wb_valid, 0);
    check("sq2_nzp",      o_nzp,      3'b100);
    check("sq2_retired",  o_retired,  5);

    drive(1'b1, 1'b0, OP_BRZ, 5'd0, 11'h123, 64'h200);
    step();
    check("brz_nt_redirect", o_redirect, 0);
    check("brz_nt_wb_valid", o_wb_valid, 1);
    check("brz_nt_retired",  o_retired,  6);

    drive(1'b1, 1'b0, OP_JSR, 5'd7, 11'h7FF, 64'h100);
    step();
    check("jsr_rf_we",    o_rf_we,    1);
    check("jsr_rd",       o_rf_rd,    5'd7);
    check("jsr_wdata",    o_rf_wdata, 64'h0);
    check("jsr_redirect", o_redirect, 1);
    check("jsr_target",   o_target,   11'h100);
    check("jsr_nzp",      o_nzp,      3'b010);
    check("jsr_retired",  o_retired,  7);

    drive(1'b0, 1'b0, OP_NOP, 5'd0, 11'h000, 64'h0);
    step();
    check("idle_redirect", o_redirect, 0);
    check("idle_wb_valid", o_wb_valid, 0);
    check("idle_retired",  o_retired,  7);

    drive(1'b1, 1'b0, OP_CHK, 5'd2, 11'h100, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("chk_carry",    o_carry,    1);
    check("chk_wdata",    o_rf_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    check("chk_nzp",      o_nzp,      3'b100);
    check("chk_retired",  o_retired,  8);

    drive(1'b1, 1'b1, OP_TCDH, 5'd9, 11'h101, 64'h2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_carry",    o_carry,    1);
      check("stall_rf_we",    o_rf_we,    1);
      check("stall_wdata",    o_rf_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
      check("stall_rd",       o_rf_rd,    5'd2);
      check("stall_retired",  o_retired,  8);
    end

    drive(1'b1, 1'b0, OP_TCDH, 5'd9, 11'h101, 64'h2);
    step();
    check("tcdh_carry",   o_carry,    0);
    check("tcdh_wdata",   o_rf_wdata, 64'h2);
    check("tcdh_rd",      o_rf_rd,    5'd9);
    check("tcdh_nzp",     o_nzp,      3'b001);
    check("tcdh_retired", o_retired,  9);

    drive(1'b1, 1'b0, OP_BRZP, 5'd0, 11'h102, 64'h055);
    step();
    check("brzp_redirect", o_redirect, 1);
    check("brzp_target",   o_target,   11'h055);
    check("brzp_retired",  o_retired,  10);

    drive(1'b1, 1'b1, OP_ADD, 5'd1, 11'h103, 64'h1);
    step();
    check("stallred_redirect", o_redirect, 1);
    check("stallred_target",   o_target,   11'h055);
    check("stallred_retired",  o_retired,  10);

    drive(1'b1, 1'b0, OP_ADD, 5'd1, 11'h103, 64'h1);
    step();
    check("sq3_redirect", o_redirect, 0);
    check("sq3_wb_valid", o_wb_valid, 0);
    check("sq3_retired",  o_retired,  10);

    drive(1'b1, 1'b0, 5'b11111, 5'd4, 11'h055, 64'h77);
    step();
    check("ill_illegal",  o_illegal,  1);
    check("ill_rf_we",    o_rf_we,    0);
    check("ill_redirect", o_redirect, 0);
    check("ill_wb_valid", o_wb_valid, 1);
    check("ill_nzp",      o_nzp,      3'b001);
    check("ill_retired",  o_retired,  11);

    drive(1'b1, 1'b0, OP_NOP, 5'd0, 11'h056, 64'h0);
    step();
    check("nop_illegal",  o_illegal,  0);
    check("nop_rf_we",    o_rf_we,    0);
    check("nop_retired",  o_retired,  12);

    drive(1'b1, 1'b0, OP_CHK, 5'd3, 11'h057, 64'h1);
    step();
    check("chk1_carry",   o_carry,    1);
    check("chk1_nzp",     o_nzp,      3'b001);

    drive(1'b1, 1'b0, OP_RTI, 5'd0, 11'h058, 64'h3AB);
    step();
    check("rti_redirect", o_redirect, 1);
    check("rti_target",   o_target,   11'h3AB);
    check("rti_rf_we",    o_rf_we,    0);
    check("rti_retired",  o_retired,  14);

    rst = 1'b1;
    drive(1'b1, 1'b1, OP_ADD, 5'd1, 11'h3AB, 64'h5);
    step();
    check("rst2_redirect", o_redirect, 0);
    check("rst2_target",   o_target,   0);
    check("rst2_wb_valid", o_wb_valid, 0);
    check("rst2_carry",    o_carry,    0);
    check("rst2_nzp",      o_nzp,      3'b010);
    check("rst2_retired",  o_retired,  0);
    check("rst2_wdata",    o_rf_wdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
